id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage feeding the execute-stage ALU. Registers the decoded instruction on each clock, resolves operand forwarding from the MEM and WB stages, and selects the ALU operands. Also detects load-use hazards, stalls fetch/decode and inserts a bubble, and squashes its contents on a taken-branch flush.

## Interface
- DATA_WIDTH, 32, datapath width
- ADDR_WIDTH, 5, register-index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs1, id_rs2, id_rd  in  ADDR_WIDTH  register indices
- id_rd1, id_rd2  in  DATA_WIDTH  register-file read data
- id_imm, id_pc  in  DATA_WIDTH  immediate, instruction PC
- id_alu_ctrl  in  4  ALU control code
- id_op1_pc  in  1  operand 1 = PC (AUIPC/JAL)
- id_op2_imm  in  1  operand 2 = immediate
- id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump  in  1  control bits
- mem_rd  in  ADDR_WIDTH, mem_reg_write  in  1, mem_result  in  DATA_WIDTH  EX/MEM forwarding source
- wb_rd  in  ADDR_WIDTH, wb_reg_write  in  1, wb_result  in  DATA_WIDTH  MEM/WB forwarding source
- ex_flush  in  1  taken branch/jump resolved in EX; kill ID and EX contents
- stall  out  1  hold PC and IF/ID register this cycle
- ALUop1, ALUop2  out  DATA_WIDTH  ALU operands
- ALUctrl  out  4  registered ALU control
- ex_valid  out  1  EX slot live
- ex_rd  out  ADDR_WIDTH; ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump  out  1 (all gated by ex_valid)
- ex_store_data, ex_pc, ex_imm  out  DATA_WIDTH  forwarded rs2, PC, immediate

## Operation
- **Load-use detection:** `load_use = ex_valid & ex_mem_read_q & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2)`.
- **Stall output:** `stall = load_use & ~ex_flush`.
- **Register update, in priority order each clock edge:**
  - `ex_flush`: `ex_valid <= 0`. All other fields are don't-care.
  - `load_use`: bubble, `ex_valid <= 0`.
  - Otherwise: capture all `id_*` fields, with `ex_valid <= id_valid`.
- **Forwarding (per source, rs1 and rs2 independently):**
  - Select MEM if `mem_reg_write & mem_rd != 0 & mem_rd == rs`.
  - Else select WB if `wb_reg_write & wb_rd != 0 & wb_rd == rs`.
  - Else use the registered `rd1`/`rd2`.
  - MEM has priority over WB. x0 is never forwarded.
- **Operand select:**
  - `ALUop1 = op1_pc ? pc : fwd1`.
  - `ALUop2 = op2_imm ? imm : fwd2`.
  - `ex_store_data = fwd2` always.
- **Control gating:** all `ex_*` control outputs are ANDed with `ex_valid`, so a bubble never writes registers or memory.
- A MEM-stage load result is never forwarded from MEM. The load-use stall guarantees the consumer reaches EX only when the load is in WB.

## Timing
- Reset (async assert, sync release): `ex_valid`, every control bit, `ALUctrl`, `ex_rd` and all data registers are 0. `stall` is 0.
- ID→EX latency: 1 cycle.
- `ALUop1`/`ALUop2`/`ex_store_data` are combinational from registered state plus the same-cycle `mem_*`/`wb_*` inputs.
- `stall` is combinational in the cycle the hazard exists. It lasts exactly 1 cycle per load-use; the next cycle the load sits in MEM and the register is in EX only as a bubble.
- Flush and load-use in the same cycle: flush wins, `stall = 0`, EX becomes invalid.
- Flush while `id_valid = 0`: EX becomes invalid. Harmless.
- `rst_n` asserted mid-stall: outputs return to reset values immediately.

## Structure
- Shared package `ex_pkg`:
  - `fwd_sel_t` enum: FWD_REG, FWD_MEM, FWD_WB.
  - `ex_ctrl_t` struct: reg_write, mem_read, mem_write, branch, jump, op1_pc, op2_imm, alu_ctrl.
- One sub-module `fwd_unit`: takes rs, mem/wb rd+write, and the three data values; returns the forwarded value and its `fwd_sel_t`. Instantiated twice.

## Test plan
- **Basic capture.** Reset, then `id_valid = 1`, `rd1 = 5`, `imm = 7`, `op2_imm = 1`, `alu_ctrl = 0`. Next cycle: `ALUop1 = 5`, `ALUop2 = 7`, `ex_valid = 1`.
- **MEM/WB forwarding priority.**
  - EX rs1 = 3, `mem_rd = 3` (write, result 0xAA), `wb_rd = 3` (write, result 0xBB). Expect `ALUop1 = 0xAA`.
  - Drop `mem_reg_write`. Expect 0xBB.
  - Set rs1 = 0 with matches on x0. Expect the `rd1` value.
- **Load-use.** EX holds `lw x4`, ID uses rs2 = 4. Expect `stall = 1` for exactly one cycle, then EX shows a bubble (`ex_valid = 0`, `ex_reg_write = 0`). The following cycle the consumer enters EX with `wb_result` forwarded.
- **Flush.** Assert `ex_flush` with valid ID. Next cycle: `ex_valid = 0` and `ex_mem_write = 0`. Flush and load-use together: `stall = 0`.
- **Async reset.** Drop `rst_n` mid-operation between clock edges. Outputs go to 0 before the next edge.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types for the ID/EX stage: forwarding-source select and the decoded
// control bundle carried from decode into execute.
package ex_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       op1_pc;
    logic       op2_imm;
    logic [3:0] alu_ctrl;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB beats the
// registered register-file value; x0 is never forwarded.
module fwd_unit
  import ex_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] rs_i,
  input  logic [ADDR_WIDTH-1:0] mem_rd_i,
  input  logic                  mem_reg_write_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [ADDR_WIDTH-1:0] wb_rd_i,
  input  logic                  wb_reg_write_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic [DATA_WIDTH-1:0] reg_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output fwd_sel_t              sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs_i)) begin
      sel_o = FWD_WB;
    end
  end

  always_comb begin
    unique case (sel_o)
      FWD_MEM: data_o = mem_data_i;
      FWD_WB:  data_o = wb_data_i;
      default: data_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use stall with
// bubble insertion, and flush on a taken branch resolved in EX.
module id_ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [3:0]            id_alu_ctrl,
  input  logic                  id_op1_pc,
  input  logic                  id_op2_imm,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  id_jump,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [DATA_WIDTH-1:0] wb_result,
  input  logic                  ex_flush,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [3:0]            ALUctrl,
  output logic                  ex_valid,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [DATA_WIDTH-1:0] ex_store_data,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_imm
);

  logic                  valid_q, valid_d;
  ex_ctrl_t              ctrl_q, ctrl_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;

  logic                  load_use;
  logic [DATA_WIDTH-1:0] fwd1, fwd2;
  fwd_sel_t              fwd1_sel, fwd2_sel;

  assign load_use = valid_q & ctrl_q.mem_read & (rd_q != '0) & id_valid &
                    ((rd_q == id_rs1) | (rd_q == id_rs2));
  assign stall    = load_use & ~ex_flush;

  // Flush and bubble only clear valid; the stale payload is masked by gating.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    if (ex_flush || load_use) begin
      valid_d = 1'b0;
    end else begin
      valid_d          = id_valid;
      ctrl_d.reg_write = id_reg_write;
      ctrl_d.mem_read  = id_mem_read;
      ctrl_d.mem_write = id_mem_write;
      ctrl_d.branch    = id_branch;
      ctrl_d.jump      = id_jump;
      ctrl_d.op1_pc    = id_op1_pc;
      ctrl_d.op2_imm   = id_op2_imm;
      ctrl_d.alu_ctrl  = id_alu_ctrl;
      rs1_d            = id_rs1;
      rs2_d            = id_rs2;
      rd_d             = id_rd;
      rd1_d            = id_rd1;
      rd2_d            = id_rd2;
      imm_d            = id_imm;
      pc_d             = id_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= EX_CTRL_NOP;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
    end
  end

  fwd_unit #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd1 (
    .rs_i           (rs1_q),
    .mem_rd_i       (mem_rd),
    .mem_reg_write_i(mem_reg_write),
    .mem_data_i     (mem_result),
    .wb_rd_i        (wb_rd),
    .wb_reg_write_i (wb_reg_write),
    .wb_data_i      (wb_result),
    .reg_data_i     (rd1_q),
    .data_o         (fwd1),
    .sel_o          (fwd1_sel)
  );

  fwd_unit #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd2 (
    .rs_i           (rs2_q),
    .mem_rd_i       (mem_rd),
    .mem_reg_write_i(mem_reg_write),
    .mem_data_i     (mem_result),
    .wb_rd_i        (wb_rd),
    .wb_reg_write_i (wb_reg_write),
    .wb_data_i      (wb_result),
    .reg_data_i     (rd2_q),
    .data_o         (fwd2),
    .sel_o          (fwd2_sel)
  );

  // x0 must always read its register value, never a forwarded one.
  always_comb begin
    assert ((fwd1_sel == FWD_REG) || (rs1_q != '0));
    assert ((fwd2_sel == FWD_REG) || (rs2_q != '0));
  end

  assign ALUop1        = ctrl_q.op1_pc  ? pc_q  : fwd1;
  assign ALUop2        = ctrl_q.op2_imm ? imm_q : fwd2;
  assign ex_store_data = fwd2;
  assign ALUctrl       = ctrl_q.alu_ctrl;
  assign ex_valid      = valid_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = ctrl_q.reg_write & valid_q;
  assign ex_mem_read   = ctrl_q.mem_read  & valid_q;
  assign ex_mem_write  = ctrl_q.mem_write & valid_q;
  assign ex_branch     = ctrl_q.branch    & valid_q;
  assign ex_jump       = ctrl_q.jump      & valid_q;
  assign ex_pc         = pc_q;
  assign ex_imm        = imm_q;

endmodule
